// File: rtl/fixed_mul_seq.sv
// fixed_mul_seq: signed QI.Q sequential shift-add multiplier with rounding, saturation and valid/ready handshake
module fixed_mul_seq #(
  parameter int N = 32,
  parameter int Q = 16,
  parameter int R = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [N-1:0] opA_i,
  input  logic [N-1:0] opB_i,
  input  logic         round_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] result_o,
  output logic         ovf_o,
  output logic         busy_o
);
  localparam int S = N / R;
  localparam int CW = $clog2(S + 1);
  localparam int HS = (Q > 0) ? Q - 1 : 0;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3;
  localparam logic [2*N:0] HALF = (Q > 0) ? ((2*N+1)'(1) << HS) : '0;
  localparam logic [2*N:0] PMAX = {{(N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic [2*N:0] NMAX = PMAX + (2*N+1)'(1);

  if ((N % R) != 0 || Q >= N || Q < 0) begin : g_bad_params
    $error("fixed_mul_seq: N must be a multiple of R and 0 <= Q < N");
  end

  logic [1:0]     state_q, state_d;
  logic [2*N-1:0] a_q, a_d, acc_q, acc_d;
  logic [N-1:0]   b_q, b_d, res_q, res_d, abs_a, abs_b;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sgn_q, sgn_d, rnd_q, rnd_d, ovf_q, ovf_d;
  logic [2*N:0]   sum, m;

  assign ready_o  = state_q == IDLE;
  assign valid_o  = state_q == DONE;
  assign busy_o   = state_q != IDLE;
  assign result_o = res_q;
  assign ovf_o    = ovf_q;

  // magnitudes of incoming operands and the rounded, rescaled product magnitude
  always_comb begin
    abs_a = opA_i[N-1] ? -opA_i : opA_i;
    abs_b = opB_i[N-1] ? -opB_i : opB_i;
    sum   = {1'b0, acc_q} + (rnd_q ? HALF : '0);
    m     = sum >> Q;
  end

  // FSM and datapath next-state: accept, shift-add R bits per cycle, round/saturate, hold for consumer
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    rnd_d   = rnd_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (valid_i) begin
        a_d     = {{N{1'b0}}, abs_a};
        b_d     = abs_b;
        sgn_d   = opA_i[N-1] ^ opB_i[N-1];
        rnd_d   = round_i;
        acc_d   = '0;
        cnt_d   = CW'(S - 1);
        state_d = RUN;
      end
      RUN: begin
        acc_d   = acc_q + a_q * (2*N)'(b_q[R-1:0]);
        a_d     = a_q << R;
        b_d     = b_q >> R;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        state_d = (cnt_q == '0) ? FIX : RUN;
      end
      FIX: begin
        res_d   = sgn_q ? ((m > NMAX) ? {1'b1, {(N-1){1'b0}}} : -m[N-1:0])
                        : ((m > PMAX) ? {1'b0, {(N-1){1'b1}}} : m[N-1:0]);
        ovf_d   = sgn_q ? (m > NMAX) : (m > PMAX);
        state_d = DONE;
      end
      DONE: state_d = ready_i ? IDLE : DONE;
    endcase
  end

  // state registers with synchronous reset that aborts any operation in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      rnd_q   <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      rnd_q   <= rnd_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_fixed_mul_seq.sv
// tb_fixed_mul_seq: directed and randomized checks of fixed_mul_seq for R=1 and R=4 builds
module tb_fixed_mul_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic v1 = 1'b0, rn1 = 1'b0, rd1 = 1'b1, rdy1o, vo1, ovf1, busy1;
  logic [31:0] a1 = '0, b1 = '0, res1;
  logic v4 = 1'b0, rn4 = 1'b0, rd4 = 1'b1, rdy4o, vo4, ovf4, busy4;
  logic [31:0] a4 = '0, b4 = '0, res4;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  fixed_mul_seq #(.N(32), .Q(16), .R(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(v1), .ready_o(rdy1o), .opA_i(a1), .opB_i(b1),
    .round_i(rn1), .valid_o(vo1), .ready_i(rd1), .result_o(res1), .ovf_o(ovf1), .busy_o(busy1));

  fixed_mul_seq #(.N(32), .Q(16), .R(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(v4), .ready_o(rdy4o), .opA_i(a4), .opB_i(b4),
    .round_i(rn4), .valid_o(vo4), .ready_i(rd4), .result_o(res4), .ovf_o(ovf4), .busy_o(busy4));

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic r);
    logic [31:0] ta, tb;
    logic [63:0] p, m;
    ta = a[31] ? (~a + 32'd1) : a;
    tb = b[31] ? (~b + 32'd1) : b;
    p = {32'h0, ta} * {32'h0, tb};
    m = (p + (r ? 64'h8000 : 64'h0)) >> 16;
    if (!(a[31] ^ b[31])) return (m > 64'h7FFF_FFFF) ? {1'b1, 32'h7FFF_FFFF} : {1'b0, m[31:0]};
    return (m > 64'h8000_0000) ? {1'b1, 32'h8000_0000} : {1'b0, ~m[31:0] + 32'd1};
  endfunction

  task automatic start1(input logic [31:0] a, input logic [31:0] b, input logic r);
    @(negedge clk);
    checks++;
    if (rdy1o !== 1'b1) begin errors++; $display("FAIL accept_ready1: ready_o=%b want 1", rdy1o); end
    a1 = a; b1 = b; rn1 = r; v1 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0; rn1 = ~r; a1 = $urandom; b1 = $urandom;
  endtask

  task automatic wait1(output int lat);
    lat = 0;
    while (!vo1 && lat < 200) begin @(posedge clk); #1; lat++; end
    checks++;
    if (vo1 !== 1'b1) begin errors++; $display("FAIL timeout1: valid_o=%b want 1", vo1); end
  endtask

  task automatic run1(input string nm, input logic [31:0] a, input logic [31:0] b, input logic r,
                      input logic [31:0] er, input logic eo, input int el);
    int lat;
    start1(a, b, r);
    wait1(lat);
    checks++;
    if (res1 !== er || ovf1 !== eo) begin
      errors++; $display("FAIL %s: result=%h ovf=%b want %h ovf=%b", nm, res1, ovf1, er, eo);
    end
    if (el > 0) begin
      checks++;
      if (lat != el) begin errors++; $display("FAIL %s_latency: %0d want %0d", nm, lat, el); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input string nm, input logic [31:0] a, input logic [31:0] b, input logic r,
                      input logic [31:0] er, input logic eo, input int el);
    int lat;
    @(negedge clk);
    a4 = a; b4 = b; rn4 = r; v4 = 1'b1;
    @(posedge clk);
    #1;
    v4 = 1'b0; rn4 = ~r; a4 = $urandom; b4 = $urandom;
    lat = 0;
    while (!vo4 && lat < 200) begin @(posedge clk); #1; lat++; end
    checks++;
    if (res4 !== er || ovf4 !== eo || vo4 !== 1'b1) begin
      errors++; $display("FAIL %s: result=%h ovf=%b valid=%b want %h ovf=%b valid=1", nm, res4, ovf4, vo4, er, eo);
    end
    if (el > 0) begin
      checks++;
      if (lat != el) begin errors++; $display("FAIL %s_latency: %0d want %0d", nm, lat, el); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (rdy1o !== 1'b1 || vo1 !== 1'b0 || busy1 !== 1'b0 || res1 !== 32'h0 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b busy=%b result=%h ovf=%b want 1 0 0 00000000 0",
               rdy1o, vo1, busy1, res1, ovf1);
    end
  endtask

  task automatic test_basic;
    run1("basic_pos", 32'h0001_8000, 32'h0002_0000, 1'b0, 32'h0003_0000, 1'b0, 33);
    run1("basic_neg", 32'hFFFE_8000, 32'h0002_0000, 1'b0, 32'hFFFD_0000, 1'b0, 33);
    run1("basic_negneg", 32'hFFFE_8000, 32'hFFFE_0000, 1'b1, 32'h0003_0000, 1'b0, 0);
  endtask

  task automatic test_rounding;
    run1("trunc_pos", 32'h0000_0001, 32'h0000_8000, 1'b0, 32'h0000_0000, 1'b0, 0);
    run1("round_pos", 32'h0000_0001, 32'h0000_8000, 1'b1, 32'h0000_0001, 1'b0, 0);
    run1("round_neg", 32'hFFFF_FFFF, 32'h0000_8000, 1'b1, 32'hFFFF_FFFF, 1'b0, 0);
    run1("trunc_neg", 32'hFFFF_FFFF, 32'h0000_8000, 1'b0, 32'h0000_0000, 1'b0, 0);
  endtask

  task automatic test_saturation;
    run1("sat_maxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 0);
    run1("sat_minmin", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 0);
    run1("min_times_one", 32'h8000_0000, 32'h0001_0000, 1'b0, 32'h8000_0000, 1'b0, 0);
    run1("sat_neg", 32'h8000_0000, 32'h0002_0000, 1'b0, 32'h8000_0000, 1'b1, 0);
  endtask

  task automatic test_backpressure;
    int lat;
    rd1 = 1'b0;
    start1(32'h0001_8000, 32'h0002_0000, 1'b0);
    wait1(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v1 = 1'b1; a1 = 32'h0004_0000; b1 = 32'h0004_0000;
      @(posedge clk);
      #1;
      checks++;
      if (vo1 !== 1'b1 || res1 !== 32'h0003_0000 || rdy1o !== 1'b0) begin
        errors++; $display("FAIL hold_%0d: valid=%b result=%h ready=%b want 1 00030000 0", i, vo1, res1, rdy1o);
      end
    end
    @(negedge clk);
    v1 = 1'b0; rd1 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rdy1o !== 1'b1 || vo1 !== 1'b0 || res1 !== 32'h0003_0000) begin
      errors++; $display("FAIL release: ready=%b valid=%b result=%h want 1 0 00030000", rdy1o, vo1, res1);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vo1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL no_ghost: valid=%b busy=%b want 0 0", vo1, busy1);
    end
  endtask

  task automatic test_reset_midop;
    start1(32'h0001_8000, 32'h0002_0000, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (rdy1o !== 1'b1 || vo1 !== 1'b0 || res1 !== 32'h0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL midop_reset: ready=%b valid=%b result=%h busy=%b want 1 0 00000000 0",
                         rdy1o, vo1, res1, busy1);
    end
    run1("after_reset", 32'hFFFE_8000, 32'h0002_0000, 1'b0, 32'hFFFD_0000, 1'b0, 33);
  endtask

  task automatic test_r4;
    run4("r4_basic", 32'h0001_8000, 32'h0002_0000, 1'b0, 32'h0003_0000, 1'b0, 9);
    run4("r4_round_neg", 32'hFFFF_FFFF, 32'h0000_8000, 1'b1, 32'hFFFF_FFFF, 1'b0, 9);
    run4("r4_sat", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 9);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic r;
    logic [32:0] e;
    for (int i = 0; i < 150; i++) begin
      a = 32'($signed($urandom) >>> $urandom_range(0, 24));
      b = 32'($signed($urandom) >>> $urandom_range(0, 24));
      r = 1'($urandom_range(0, 1));
      e = model(a, b, r);
      run1("rand_r1", a, b, r, e[31:0], e[32], 33);
      run4("rand_r4", a, b, r, e[31:0], e[32], 9);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_rounding;
    test_saturation;
    test_backpressure;
    test_reset_midop;
    test_r4;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
